// File: rtl/mux4_rr_sel_arbiter_pkg.sv
// Shared types for the 4:1 mux round-robin select arbiter.
// Select type, source count and arbiter state encoding.
package mux_pkg;
  localparam int NUM_SRC = 4;
  typedef logic [1:0] sel_t;
  typedef enum logic {
    IDLE,
    GRANT
  } state_t;
endpackage

// File: rtl/mux4_rr_sel_arbiter_if.sv
// Request/grant bundle between requesters and the select arbiter.
// master: req, done out; slave (arbiter): sel, grant, busy, timeout out.
interface mux4_rr_sel_arbiter_if;
  import mux_pkg::*;
  logic [NUM_SRC-1:0] req;
  logic               done;
  sel_t               sel;
  logic [NUM_SRC-1:0] grant;
  logic               busy;
  logic               timeout;

  modport master (
    output req, done,
    input  sel, grant, busy, timeout
  );

  modport slave (
    input  req, done,
    output sel, grant, busy, timeout
  );
endinterface

// File: rtl/mux4_rr_sel_arbiter_rr_pick4.sv
// Combinational rotating-priority pick over four requests.
// In: req, ptr. Out: idx of first set bit from ptr upward, found flag.
module rr_pick4
  import mux_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  sel_t               ptr,
  output sel_t               idx,
  output logic               found
);
  sel_t cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = ptr + sel_t'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux4_rr_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 data mux.
// Ports: clk, rst (async high), bus (slave: req/done in; sel/grant/busy/timeout out).
module mux4_rr_sel_arbiter
  import mux_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux4_rr_sel_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_MAX - 1);

  state_t             state;
  sel_t               ptr;
  sel_t               sel;
  logic [NUM_SRC-1:0] grant;
  logic               busy;
  logic               timeout;
  logic [CNT_W-1:0]   cnt;

  sel_t pick;
  logic found;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .idx   (pick),
    .found (found)
  );

  logic owner_req;
  logic at_limit;
  logic release_now;

  assign owner_req   = bus.req[sel];
  assign at_limit    = (cnt == LAST);
  assign release_now = bus.done || !owner_req || at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      sel     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            grant <= NUM_SRC'(1) << pick;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            grant   <= '0;
            busy    <= 1'b0;
            ptr     <= sel + 2'd1;
            state   <= IDLE;
            // only a pure limit release flags timeout
            timeout <= !bus.done && owner_req;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel     = sel;
  assign bus.grant   = grant;
  assign bus.busy    = busy;
  assign bus.timeout = timeout;
endmodule

// File: tb/tb_mux4_rr_sel_arbiter.sv
// Directed bench for mux4_rr_sel_arbiter with HOLD_MAX=3.
// Covers single req, fairness, timeout, simultaneous release, drop, reset.
module tb_mux4_rr_sel_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  mux4_rr_sel_arbiter_if bus ();

  mux4_rr_sel_arbiter #(
    .HOLD_MAX (3),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] s,
                            input logic [3:0] g, input logic b,
                            input logic t);
    check({tag, ".sel"},     8'(bus.sel),     8'(s));
    check({tag, ".grant"},   8'(bus.grant),   8'(g));
    check({tag, ".busy"},    8'(bus.busy),    8'(b));
    check({tag, ".timeout"}, 8'(bus.timeout), 8'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #2;
    expect_out("reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    expect_out("idle", 2'd0, 4'b0000, 1'b0, 1'b0);

    // single request
    bus.req = 4'b0100;
    step();
    expect_out("single", 2'd2, 4'b0100, 1'b1, 1'b0);
    bus.done = 1'b1;
    step();
    expect_out("single_rel", 2'd2, 4'b0000, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b1111;
    step();
    expect_out("ptr_after", 2'd3, 4'b1000, 1'b1, 1'b0);

    // fairness: done held, so ignored in IDLE
    bus.done = 1'b1;
    step();
    expect_out("fair_rel3", 2'd3, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out($sformatf("fair%0d", i), order[i],
                 4'(1 << order[i]), 1'b1, 1'b0);
      step();
      expect_out($sformatf("fair%0d_rel", i), order[i],
                 4'b0000, 1'b0, 1'b0);
    end
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    step();
    expect_out("quiet", 2'd0, 4'b0000, 1'b0, 1'b0);

    // timeout, ptr=1
    bus.req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("hold%0d", i), 2'd1, 4'b0010, 1'b1, 1'b0);
    end
    step();
    expect_out("to_pulse", 2'd1, 4'b0000, 1'b0, 1'b1);
    step();
    expect_out("regrant", 2'd1, 4'b0010, 1'b1, 1'b0);

    // done on the limit cycle
    step();
    expect_out("sim_c1", 2'd1, 4'b0010, 1'b1, 1'b0);
    step();
    expect_out("sim_c2", 2'd1, 4'b0010, 1'b1, 1'b0);
    bus.done = 1'b1;
    step();
    expect_out("sim_rel", 2'd1, 4'b0000, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    step();
    expect_out("sim_idle", 2'd1, 4'b0000, 1'b0, 1'b0);

    // request drop, ptr=2
    bus.req = 4'b1001;
    step();
    expect_out("drop_own", 2'd3, 4'b1000, 1'b1, 1'b0);
    bus.req = 4'b0001;
    step();
    expect_out("drop_rel", 2'd3, 4'b0000, 1'b0, 1'b0);
    step();
    expect_out("drop_next", 2'd0, 4'b0001, 1'b1, 1'b0);
    bus.done = 1'b1;
    step();
    expect_out("drop_done", 2'd0, 4'b0000, 1'b0, 1'b0);
    bus.done = 1'b0;

    // async reset mid-grant, ptr=1
    bus.req = 4'b0100;
    step();
    expect_out("pre_rst", 2'd2, 4'b0100, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 2'd0, 4'b0000, 1'b0, 1'b0);
    bus.req = 4'b0101;
    #1;
    rst = 1'b0;
    step();
    expect_out("post_rst", 2'd0, 4'b0001, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
